// File: rtl/swu_rom_seq.sv
// -----------------------------------------------------------------------------
// swu_rom_seq
// Streams a contiguous window of a registered-read ROM onto a valid/ready
// output channel. A window is requested with start/base_addr/len while idle;
// illegal windows (empty, or running past the end of the ROM) are rejected
// with a one-cycle err pulse. Reads are throttled by the consumer so that a
// stalled word is held in the ROM's own output register rather than buffered.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   start      : one-cycle window request, honoured only when idle
//   base_addr  : first ROM address of the window (sampled with start)
//   len        : word count of the window, 1..DEPTH (sampled with start)
//   abort      : cancel the window in progress, back to idle next edge
//   rom_en     : ROM read enable (ROM captures rom[rom_addr] next edge)
//   rom_addr   : ROM read address
//   rom_data   : ROM registered read data
//   out_data   : streamed word (rom_data passed through)
//   out_valid  : out_data holds a word not yet accepted
//   out_ready  : consumer accepts the word this cycle
//   out_last   : current beat is the final beat of the window
//   busy       : sequencer is not idle
//   done       : one-cycle pulse after the final beat transfers
//   err        : one-cycle pulse after a rejected start
// -----------------------------------------------------------------------------
module swu_rom_seq #(
  parameter int DEPTH = 29,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  input  logic          abort,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_e;

  localparam logic [AW:0]   ONE     = (AW+1)'(1);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] base_q,  base_d;
  logic [AW:0]   len_q,   len_d;
  logic [AW:0]   issue_q, issue_d;
  logic [AW:0]   beat_q,  beat_d;
  logic          out_valid_q, out_valid_d;
  logic          err_q,       err_d;

  logic          stall;
  logic          xfer;
  logic          start_ok;
  logic [AW+1:0] win_end;
  logic [AW:0]   addr_off;

  // Window end computed two bits wider than base_addr so that an oversized
  // request cannot wrap back into the legal range.
  assign win_end  = {2'b00, base_addr} + {1'b0, len};
  assign start_ok = (len != '0) && (win_end <= DEPTH_W);

  assign stall = out_valid_q & ~out_ready;
  assign xfer  = out_valid_q & out_ready;

  assign rom_en = (state_q == FETCH) && (issue_q < len_q) && !stall;

  // Once every address of the window has been issued the issue count equals
  // len; hold the address on the last issued word instead of stepping one
  // past the window (which could point beyond the end of the ROM).
  assign addr_off = ((issue_q != '0) && (issue_q == len_q)) ? (len_q - ONE) : issue_q;
  assign rom_addr = base_q + addr_off[AW-1:0];

  assign out_data  = rom_data;
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q && (beat_q == len_q - ONE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issue_d     = issue_q;
    beat_d      = beat_q;
    err_d       = 1'b0;
    // A word stays valid until accepted; a new one appears one cycle after
    // each read because the ROM output is registered.
    out_valid_d = rom_en | stall;

    if (rom_en) issue_d = issue_q + ONE;
    if (xfer)   beat_d  = beat_q + ONE;

    unique case (state_q)
      IDLE: begin
        issue_d = '0;
        beat_d  = '0;
        // abort in the same cycle drops the request without an err pulse
        if (start && !abort) begin
          if (start_ok) begin
            base_d  = base_addr;
            len_d   = len;
            state_d = FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FETCH: if (rom_en && (issue_q == len_q - ONE)) state_d = DRAIN;
      DRAIN: if (xfer && (beat_q == len_q - ONE))    state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      issue_d     = '0;
      beat_d      = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_q     <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issue_q     <= issue_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_swu_rom_seq.sv
// -----------------------------------------------------------------------------
// tb_swu_rom_seq
// Self-checking bench for swu_rom_seq. A registered ROM model feeds the DUT;
// each window is scored against the words rom_m[base .. base+len-1] that the
// consumer should see, in order, with out_last on the final one and a single
// done cycle afterwards.
// -----------------------------------------------------------------------------
module tb_swu_rom_seq;

  localparam int DEPTH = 29;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          abort;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err;

  logic [DW-1:0] rom_m [DEPTH];
  int            n_vec;
  int            n_err;

  swu_rom_seq #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .abort     (abort),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read ROM: holds its output while rom_en is low.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_m[rom_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_en"},    rom_en,    0);
    check({tag, "_rom_addr"},  rom_addr,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_err"},       err,       0);
  endtask

  // mode 0: always ready, 1: repeating 1,0,0 pattern, 2: random
  function automatic logic pick_ready(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((cyc - 1) % 3) == 0;
    return 1'($urandom_range(1));
  endfunction

  // kill 0: none, 1: abort, 2: one-cycle reset; applied on beat kill_beat
  task automatic run_window(input int base, input int n, input int mode,
                            input int kill, input int kill_beat);
    int k;
    int iss;
    int cyc;
    bit first_seen;
    bit done_seen;
    bit finished;
    bit prev_stall;
    logic [DW-1:0] prev_data;
    k = 0; iss = 0; cyc = 0;
    first_seen = 0; done_seen = 0; finished = 0; prev_stall = 0;
    prev_data = '0;

    @(negedge clk);
    start     = 1'b1;
    abort     = 1'b0;
    base_addr = AW'(base);
    len       = (AW+1)'(n);
    out_ready = pick_ready(mode, 0);
    #1;
    check("idle_rom_en", rom_en, 0);

    while (!finished && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start     = 1'b0;
      abort     = 1'b0;
      out_ready = pick_ready(mode, cyc);
      // a stray illegal start while busy must be ignored without err
      if (k < n && $urandom_range(3) == 0) begin
        start     = 1'b1;
        len       = '0;
        base_addr = AW'($urandom);
      end
      #1;
      check("no_err", err, 0);
      if (rom_en) begin
        check("over_issue", iss < n, 1);
        check("rom_addr", rom_addr, base + iss);
        iss++;
      end

      if (k == n) begin
        if (!done_seen) begin
          check("issued", iss, n);
          check("done_pulse", done, 1);
          check("done_busy", busy, 1);
          check("done_valid", out_valid, 0);
          done_seen = 1;
        end else begin
          check("post_done", done, 0);
          check("post_busy", busy, 0);
          finished = 1;
        end
      end else begin
        check("busy", busy, 1);
        check("done_early", done, 0);
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, prev_data);
        end
        check("out_last", out_last, out_valid && (k == n - 1));
        if (out_valid && !first_seen) begin
          check("latency", cyc, 2);
          first_seen = 1;
        end

        if (kill != 0 && k == kill_beat && out_valid) begin
          start = 1'b0;
          if (kill == 1) abort = 1'b1;
          else           rst_n = 1'b0;
          @(negedge clk);
          abort = 1'b0;
          #1;
          if (kill == 1) begin
            check("abort_busy",  busy,      0);
            check("abort_valid", out_valid, 0);
            check("abort_done",  done,      0);
          end else begin
            check_reset_outputs("rst_mid");
            rst_n = 1'b1;
            check("rst_release_rom_en", rom_en, 0);
          end
          @(negedge clk);
          #1;
          check("kill_no_done", done,   0);
          check("kill_idle",    busy,   0);
          check("kill_rom_en",  rom_en, 0);
          return;
        end

        if (out_valid && out_ready) begin
          check("beat_data", out_data, rom_m[base + k]);
          k++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
    if (!finished) check("timeout", 1'b1, 1'b0);
    start = 1'b0;
  endtask

  task automatic bad_start(input int base, input int n);
    @(negedge clk);
    start     = 1'b1;
    abort     = 1'b0;
    base_addr = AW'(base);
    len       = (AW+1)'(n);
    out_ready = 1'b1;
    #1;
    check("bad_rom_en0", rom_en, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("bad_err",     err,    1);
    check("bad_busy",    busy,   0);
    check("bad_rom_en1", rom_en, 0);
    @(negedge clk);
    #1;
    check("bad_err_clr", err,  0);
    check("bad_busy2",   busy, 0);
  endtask

  initial begin
    int bl;
    int bb;
    n_vec = 0;
    n_err = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    len       = '0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom_m[i] = $urandom;

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_window(0, 29, 0, 0, 0);   // full ROM, back-to-back
    run_window(10, 5, 1, 0, 0);   // patterned backpressure
    bad_start(25, 5);             // runs past the end
    bad_start(0, 0);              // empty window
    run_window(28, 1, 0, 0, 0);   // single word at the last address
    run_window(0, 8, 0, 1, 2);    // abort on the third beat
    run_window(0, 8, 2, 0, 0);    // fresh start completes afterwards
    run_window(0, 8, 0, 2, 3);    // reset mid-stream
    run_window(3, 2, 0, 0, 0);

    // abort and start together while idle: start is dropped
    @(negedge clk);
    start = 1'b1; abort = 1'b1; base_addr = AW'(2); len = (AW+1)'(4);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    check("idle_abort_busy",   busy,   0);
    check("idle_abort_err",    err,    0);
    check("idle_abort_rom_en", rom_en, 0);

    for (int t = 0; t < 20; t++) begin
      bl = $urandom_range(1, DEPTH);
      bb = $urandom_range(0, DEPTH - bl);
      run_window(bb, bl, $urandom_range(2), 0, 0);
    end
    for (int t = 0; t < 5; t++) begin
      bl = $urandom_range(1, DEPTH);
      bb = $urandom_range(DEPTH - bl + 1, (1 << AW) - 1);
      bad_start(bb, bl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
